button_conditioner: RTL and testbench

// - Parametrised front end for all player inputs: per-channel synchronise, debounce, edge detect, auto-repeat.
// - Sits between the board pins (left/right/A/B/switches) and the game controller.
// - The controller consumes clean levels and one-cycle event pulses instead of raw pins.
// - Channel count and timing are set per build; repeat is enabled per channel (paddle keys yes, release key no).

---
 rtl/button_conditioner_if.sv | 31 +++
 rtl/button_conditioner.sv | 107 ++++++++++
 tb/tb_button_conditioner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: pin and event signals of button_conditioner; INPUT_LATCH_EN adds LATCH_ACK/BTN_LATCHED
interface button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] BTN_IN;
  logic [NUM_BTN-1:0] BTN_LEVEL;
  logic [NUM_BTN-1:0] BTN_PRESS;
  logic [NUM_BTN-1:0] BTN_RELEASE;
  logic [NUM_BTN-1:0] BTN_REPEAT;
`ifdef INPUT_LATCH_EN
  logic               LATCH_ACK;
  logic [NUM_BTN-1:0] BTN_LATCHED;
  modport master (
    output BTN_IN, LATCH_ACK,
    input  BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, BTN_LATCHED
  );
  modport slave (
    input  BTN_IN, LATCH_ACK,
    output BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT, BTN_LATCHED
  );
`else
  modport master (
    output BTN_IN,
    input  BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT
  );
  modport slave (
    input  BTN_IN,
    output BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT
  );
`endif
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel sync, debounce, edge pulses and auto-repeat; INPUT_LATCH_EN adds a sticky press latch
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 400000,
  parameter int                 REPEAT_DELAY    = 16000000,
  parameter int                 REPEAT_PERIOD   = 3200000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(4'b0011)
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  button_conditioner_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DELAY, RUN} rpt_state_t;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  if (NUM_BTN < 1 || NUM_BTN > 16 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_conditioner: parameter out of legal range");
  end
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q;
  logic [NUM_BTN-1:0] s, level, press, rel, tick;
  assign s = sync_q[SYNC_STAGES-1];
  // shift the raw pins through the synchroniser chain
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], bus.BTN_IN};
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [CW-1:0] cnt_q;
    logic          lvl_q, prs_q, rls_q, flip, tck;
    rpt_state_t    state_q, state_d;
    logic [RW-1:0] rc_q, rc_d;
    assign flip     = (s[i] != lvl_q) && cnt_q == DB_LAST;
    assign level[i] = lvl_q;
    assign press[i] = prs_q;
    assign rel[i]   = rls_q;
    assign tick[i]  = tck;
    // count cycles of disagreement; flip the level and emit the edge pulse when it persists long enough
    always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rls_q <= 1'b0;
      end else begin
        cnt_q <= (s[i] == lvl_q || flip) ? '0 : cnt_q + 1'b1;
        lvl_q <= flip ? s[i] : lvl_q;
        prs_q <= flip & s[i];
        rls_q <= flip & ~s[i];
      end
    // repeat state and tick counter registers
    always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
        state_q <= IDLE;
        rc_q    <= '0;
      end else begin
        state_q <= state_d;
        rc_q    <= rc_d;
      end
    // repeat FSM: initial delay after press, then periodic ticks; a low level forces IDLE without a tick
    always_comb begin
      state_d = state_q;
      rc_d    = rc_q + 1'b1;
      tck     = 1'b0;
      if (!lvl_q || !REPEAT_MASK[i]) begin
        state_d = IDLE;
        rc_d    = '0;
      end else begin
        case (state_q)
          IDLE: begin
            rc_d    = '0;
            state_d = prs_q ? DELAY : IDLE;
          end
          DELAY: if (rc_q == DLY_LAST) begin
            tck     = 1'b1;
            state_d = RUN;
            rc_d    = '0;
          end
          RUN: if (rc_q == PER_LAST) begin
            tck  = 1'b1;
            rc_d = '0;
          end
          default: begin
            state_d = IDLE;
            rc_d    = '0;
          end
        endcase
      end
    end
  end
  assign bus.BTN_LEVEL   = level;
  assign bus.BTN_PRESS   = press;
  assign bus.BTN_RELEASE = rel;
  assign bus.BTN_REPEAT  = press | tick;
`ifdef INPUT_LATCH_EN
  logic [NUM_BTN-1:0] latched_q;
  assign bus.BTN_LATCHED = latched_q;
  // sticky press flags; a press in the ack cycle survives so no press is lost across a frame
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) latched_q <= '0;
    else latched_q <= press | (bus.LATCH_ACK ? '0 : latched_q);
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed vectors for button_conditioner (define INPUT_LATCH_EN to cover the latch)
module tb_button_conditioner;
  logic CLK = 1'b0;
  logic RESET_N;
  int   n_vec = 0;
  int   n_err = 0;
  always #5 CLK = ~CLK;
  button_conditioner_if #(.NUM_BTN(4)) bus ();
  button_conditioner #(
    .NUM_BTN(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_MASK(4'b0011)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  initial begin
    RESET_N    = 1'b0;
    bus.BTN_IN = 4'h0;
`ifdef INPUT_LATCH_EN
    bus.LATCH_ACK = 1'b0;
`endif
    step(3);
    check("rst_all", {bus.BTN_LEVEL, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_REPEAT}, 16'h0);
    RESET_N = 1'b1;
    step(8);
    check("idle_level", bus.BTN_LEVEL, 4'h0);
    bus.BTN_IN = 4'hF;
    step(6);
    check("first_level", bus.BTN_LEVEL, 4'hF);
    check("first_press", bus.BTN_PRESS, 4'hF);
    step(2);
    RESET_N = 1'b0;
    #2;
    check("async_rst", {bus.BTN_LEVEL, bus.BTN_PRESS, bus.BTN_RELEASE, bus.BTN_REPEAT}, 16'h0);
    RESET_N = 1'b1;
    step(5);
    check("post_rst_e5_level", bus.BTN_LEVEL, 4'h0);
    check("post_rst_e5_press", bus.BTN_PRESS, 4'h0);
    step(1);
    check("post_rst_e6_level", bus.BTN_LEVEL, 4'hF);
    check("post_rst_e6_press", bus.BTN_PRESS, 4'hF);
    step(1);
    check("post_rst_e7_press", bus.BTN_PRESS, 4'h0);
    check("post_rst_e7_level", bus.BTN_LEVEL, 4'hF);
    bus.BTN_IN = 4'h0;
    step(6);
    check("all_release", bus.BTN_RELEASE, 4'hF);
    check("all_release_level", bus.BTN_LEVEL, 4'h0);
    check("all_release_rpt", bus.BTN_REPEAT, 4'h0);
    step(1);
    check("all_release_once", bus.BTN_RELEASE, 4'h0);
    bus.BTN_IN = 4'b0100;
    step(3);
    bus.BTN_IN = 4'h0;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      check($sformatf("glitch_c%0d", c), {bus.BTN_LEVEL, bus.BTN_PRESS, bus.BTN_RELEASE}, 12'h0);
    end
    bus.BTN_IN = 4'b0100;
    step(5);
    check("hold_e5_level", bus.BTN_LEVEL, 4'h0);
    step(1);
    check("hold_e6_level", bus.BTN_LEVEL, 4'b0100);
    check("hold_e6_press", bus.BTN_PRESS, 4'b0100);
    check("hold_e6_rpt", bus.BTN_REPEAT, 4'b0100);
    step(1);
    check("hold_e7_press", bus.BTN_PRESS, 4'h0);
    bus.BTN_IN = 4'h0;
    step(6);
    check("hold_release", bus.BTN_RELEASE, 4'b0100);
    step(2);
    bus.BTN_IN = 4'b0011;
    step(6);
    check("rpt_press", bus.BTN_PRESS, 4'b0011);
    check("rpt_p0", bus.BTN_REPEAT, 4'b0011);
    for (int c = 1; c <= 25; c++) begin
      logic [1:0] er;
      step(1);
      er[0] = (c == 10 || c == 13);
      er[1] = (c == 10 || c == 13 || c == 16 || c == 19 || c == 22 || c == 25);
      check($sformatf("rpt_c%0d", c), bus.BTN_REPEAT, {2'b00, er});
      check($sformatf("rpt_rel_c%0d", c), bus.BTN_RELEASE, (c == 14) ? 4'b0001 : 4'b0000);
      if (c == 8) bus.BTN_IN = 4'b0010;
    end
    bus.BTN_IN = 4'h0;
    step(10);
    check("rpt_done_level", bus.BTN_LEVEL, 4'h0);
    bus.BTN_IN = 4'b1000;
    step(6);
    check("norpt_press", bus.BTN_PRESS, 4'b1000);
    check("norpt_rpt", bus.BTN_REPEAT, 4'b1000);
    for (int c = 1; c <= 30; c++) begin
      step(1);
      check($sformatf("norpt_c%0d", c), bus.BTN_REPEAT, 4'h0);
    end
    bus.BTN_IN = 4'h0;
    step(8);
    bus.BTN_IN = 4'b0101;
    step(5);
    check("simul_e5", bus.BTN_PRESS, 4'h0);
    step(1);
    check("simul_e6", bus.BTN_PRESS, 4'b0101);
    step(1);
    check("simul_e7", bus.BTN_PRESS, 4'h0);
    bus.BTN_IN = 4'h0;
    step(8);
`ifdef INPUT_LATCH_EN
    check("latch_clear", bus.BTN_LATCHED, 4'h0);
    bus.BTN_IN = 4'b0010;
    step(6);
    check("latch_press", bus.BTN_PRESS, 4'b0010);
    step(1);
    check("latch_set", bus.BTN_LATCHED, 4'b0010);
    bus.LATCH_ACK = 1'b1;
    step(1);
    bus.LATCH_ACK = 1'b0;
    check("latch_ack", bus.BTN_LATCHED, 4'h0);
    bus.BTN_IN = 4'h0;
    step(8);
    bus.BTN_IN = 4'b0010;
    step(6);
    check("latch_press2", bus.BTN_PRESS, 4'b0010);
    bus.LATCH_ACK = 1'b1;
    step(1);
    bus.LATCH_ACK = 1'b0;
    check("latch_set_wins", bus.BTN_LATCHED, 4'b0010);
    step(1);
    check("latch_hold", bus.BTN_LATCHED, 4'b0010);
    bus.BTN_IN = 4'h0;
    step(8);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
